// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 7-segment display path.
//   NDIG_DEF      default number of scanned digits
//   bcd_nibble_t  one decimal digit code
//   DIG_*         special digit codes understood by the downstream decoder
//   disp_mode_t   display mode encodings used across the display path
//   conv_state_t  states of the sequential binary-to-BCD converter
//   dabble_adjust add-3 correction applied to a nibble before each shift
// ---------------------------------------------------------------------------
package seg_pkg;

    localparam int NDIG_DEF = 4;

    typedef logic [3:0] bcd_nibble_t;

    // Digit codes above 9 are reserved for symbols rendered by the decoder.
    localparam bcd_nibble_t DIG_MINUS = 4'd10;
    localparam bcd_nibble_t DIG_E     = 4'd11;
    localparam bcd_nibble_t DIG_BLANK = 4'd15;

    typedef enum logic [2:0] {
        MODE_NORMAL = 3'b000,
        MODE_NEG    = 3'b001,
        MODE_ERR    = 3'b010,
        MODE_FIXED  = 3'b100
    } disp_mode_t;

    typedef enum logic {
        CONV_IDLE  = 1'b0,
        CONV_SHIFT = 1'b1
    } conv_state_t;

    // A nibble of 5 or more would exceed 9 after doubling, so pre-add 3 to
    // make the carry land in the next decimal digit.
    function automatic bcd_nibble_t dabble_adjust(input bcd_nibble_t n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential double-dabble converter: one shift per clock, DATA_W clocks per
// conversion. The result register only changes on the final shift, so bcd
// never shows a partial value.
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous reset, active low (aborts any conversion)
//   data_in  in   DATA_W-bit binary operand
//   load     in   start strobe, accepted only while idle
//   busy     out  conversion in progress
//   bcd      out  last completed result, 4*NDIG bits, nibble 0 = units
// ---------------------------------------------------------------------------
module bin_to_bcd_seq
    import seg_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NDIG   = NDIG_DEF
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                load,
    output logic                busy,
    output logic [4*NDIG-1:0]   bcd
);

    localparam int SW = 4 * NDIG;
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(DATA_W - 1);

    conv_state_t state;
    conv_state_t state_next;

    logic [DATA_W-1:0]    operand;
    logic [SW-1:0]        scratch;
    logic [SW-1:0]        scratch_adj;
    logic [SW+DATA_W-1:0] shifted;
    logic [CW-1:0]        iter;
    logic                 start;
    logic                 last;

    // Idle is the same thing as busy==0, so a load landing on the edge where
    // busy falls is still seen in SHIFT and dropped.
    assign start = (state == CONV_IDLE) && load;
    assign last  = (state == CONV_SHIFT) && (iter == LAST_ITER);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CONV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: leave IDLE on an accepted load, return after the
    // final shift.
    always_comb begin
        state_next = state;
        case (state)
            CONV_IDLE:  if (load) state_next = CONV_SHIFT;
            CONV_SHIFT: if (last) state_next = CONV_IDLE;
            default:    state_next = CONV_IDLE;
        endcase
    end

    // Output decode: busy is just the registered state.
    always_comb begin
        busy = (state == CONV_SHIFT);
    end

    // Add-3 correction on every scratch nibble, then one combined left shift
    // that moves the operand MSB into the scratch LSB.
    always_comb begin
        scratch_adj = '0;
        for (int i = 0; i < NDIG; i++) begin
            scratch_adj[4*i +: 4] = dabble_adjust(scratch[4*i +: 4]);
        end
        shifted = {scratch_adj, operand} << 1;
    end

    // Datapath registers. bcd is written once, on the last shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand <= '0;
            scratch <= '0;
            iter    <= '0;
            bcd     <= '0;
        end else if (start) begin
            operand <= data_in;
            scratch <= '0;
            iter    <= '0;
        end else if (state == CONV_SHIFT) begin
            operand <= shifted[DATA_W-1:0];
            scratch <= shifted[SW+DATA_W-1:DATA_W];
            iter    <= iter + 1'b1;
            if (last) begin
                bcd <= shifted[SW+DATA_W-1:DATA_W];
            end
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Drive side of the multiplexed 7-segment display: converts a binary value
// to BCD and scans the digits with a one-hot anode select plus the matching
// digit code. Each digit slot starts with a short all-off window to stop
// ghosting between neighbouring digits.
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous reset, active low
//   data_in  in   DATA_W-bit value to display
//   load     in   1-cycle strobe, captured when busy==0
//   busy     out  conversion in progress
//   bcd      out  last completed BCD result, nibble 0 = units
//   anodes   out  one-hot active-high digit select, zero while blanked
//   digit    out  BCD code of the selected digit
//   blank    out  high while anodes==0
// ---------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int NDIG        = NDIG_DEF,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                load,
    output logic                busy,
    output logic [4*NDIG-1:0]   bcd,
    output logic [NDIG-1:0]     anodes,
    output logic [3:0]          digit,
    output logic                blank
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

    logic [PW-1:0]   pre;
    logic [PW-1:0]   pre_next;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_next;
    logic            pre_wrap;
    logic            blank_next;
    logic [NDIG-1:0] anodes_next;
    bcd_nibble_t     digit_next;

    bin_to_bcd_seq #(
        .DATA_W (DATA_W),
        .NDIG   (NDIG)
    ) u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .load    (load),
        .busy    (busy),
        .bcd     (bcd)
    );

    // Outputs are decoded from the counters' next values and registered with
    // them, so anodes/digit/blank always describe the current counter state
    // and the anode/digit pair is coherent.
    always_comb begin
        pre_wrap = (pre == PRE_LAST);
        pre_next = pre_wrap ? '0 : (pre + 1'b1);
        idx_next = idx;
        if (pre_wrap) begin
            idx_next = (idx == IDX_LAST) ? '0 : (idx + 1'b1);
        end
        blank_next  = (pre_next < BLANK_END);
        anodes_next = blank_next ? '0 : (NDIG'(1) << idx_next);
        digit_next  = bcd[{idx_next, 2'b00} +: 4];
    end

    // Prescaler, digit index and display output registers. A bcd update only
    // changes the digit code; the slot timing keeps running untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre    <= '0;
            idx    <= '0;
            anodes <= '0;
            digit  <= '0;
            blank  <= 1'b1;
        end else begin
            pre    <= pre_next;
            idx    <= idx_next;
            anodes <= anodes_next;
            digit  <= digit_next;
            blank  <= blank_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Scoreboard bench for seg_scan_ctrl with REFRESH_DIV=8, BLANK_CYC=2.
// Accepted loads push their hand-computed BCD result; a monitor pops and
// compares on every busy falling edge. The scanner is checked against a
// cycle counter that restarts with reset.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int DATA_W      = 8;
    localparam int NDIG        = 4;
    localparam int REFRESH_DIV = 8;
    localparam int BLANK_CYC   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data_in = '0;
    logic        load = 1'b0;
    logic        busy;
    logic [15:0] bcd;
    logic [3:0]  anodes;
    logic [3:0]  digit;
    logic        blank;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [15:0] sb[$];
    int          scan_cnt;

    seg_scan_ctrl #(
        .DATA_W      (DATA_W),
        .NDIG        (NDIG),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .load    (load),
        .busy    (busy),
        .bcd     (bcd),
        .anodes  (anodes),
        .digit   (digit),
        .blank   (blank)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Clock edges seen since the last reset release, used to predict the scan.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) scan_cnt <= 0;
        else        scan_cnt <= scan_cnt + 1;
    end

    // Watchdog so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one load strobe; an accepted load queues its expected result.
    task automatic applyStimulus(input logic [7:0] value, input bit accepted,
                                 input logic [15:0] expected);
        @(negedge clk);
        data_in = value;
        load    = 1'b1;
        if (accepted) sb.push_back(expected);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic waitIdle();
        int k = 0;
        while ((busy || sb.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL idle_timeout: busy=%0b queued=%0d, expected idle", busy, sb.size());
        end
        @(negedge clk);
    endtask

    // Compare the scanner outputs over n cycles with the bcd value held fixed.
    task automatic checkScan(input int n, input logic [15:0] hold);
        int pre;
        int idx;
        logic [3:0] exp_an;
        logic [3:0] exp_dig;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            pre     = scan_cnt % REFRESH_DIV;
            idx     = (scan_cnt / REFRESH_DIV) % NDIG;
            exp_an  = (pre < BLANK_CYC) ? 4'b0000 : (4'b0001 << idx);
            exp_dig = hold[idx*4 +: 4];
            checkOutput("scan_anodes", 32'(anodes), 32'(exp_an));
            checkOutput("scan_blank", 32'(blank), (pre < BLANK_CYC) ? 32'd1 : 32'd0);
            checkOutput("scan_digit", 32'(digit), 32'(exp_dig));
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_anodes", 32'(anodes), 32'd0);
        checkOutput("rst_blank", 32'(blank), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_bcd", 32'(bcd), 32'd0);
        checkOutput("rst_digit", 32'(digit), 32'd0);
    endtask

    // Scoreboard monitor: on each busy fall check the busy length and the result.
    initial begin : monitor
        logic        prev_busy;
        int          busy_len;
        logic [15:0] expv;
        prev_busy = 1'b0;
        busy_len  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 1'b0;
                busy_len  = 0;
            end else begin
                if (busy) begin
                    busy_len++;
                end else if (prev_busy) begin
                    checkOutput("busy_len", 32'(busy_len), 32'd8);
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("[TB] FAIL unexpected_result: got 0x%0h, expected no result", bcd);
                    end else begin
                        expv = sb.pop_front();
                        checkOutput("bcd_result", 32'(bcd), 32'(expv));
                    end
                    busy_len = 0;
                end
                prev_busy = busy;
            end
        end
    end

    initial begin : stimulus
        repeat (3) @(negedge clk);
        checkResetState();
        rst_n = 1'b1;

        // First slot after reset: index 0, starting blanked, digits all zero.
        checkScan(10, 16'h0000);

        applyStimulus(8'd0, 1'b1, 16'h0000);
        waitIdle();
        applyStimulus(8'd99, 1'b1, 16'h0099);
        waitIdle();
        applyStimulus(8'd100, 1'b1, 16'h0100);
        waitIdle();
        applyStimulus(8'd255, 1'b1, 16'h0255);
        waitIdle();

        // Full scan round and wrap back to the units digit.
        checkScan(40, 16'h0255);

        // Second load three cycles after the first is ignored.
        applyStimulus(8'd200, 1'b1, 16'h0200);
        @(negedge clk);
        applyStimulus(8'd7, 1'b0, 16'h0000);
        waitIdle();
        checkOutput("bcd_after_ignored", 32'(bcd), 32'h0200);

        // Load on the edge where busy falls is ignored.
        applyStimulus(8'd33, 1'b1, 16'h0033);
        repeat (7) @(negedge clk);
        data_in = 8'd9;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("busy_after_fall_load", 32'(busy), 32'd0);
        checkOutput("bcd_after_fall_load", 32'(bcd), 32'h0033);

        // Reset mid-conversion: outputs clear at once, no partial result.
        applyStimulus(8'd255, 1'b0, 16'h0000);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkScan(12, 16'h0000);
        checkOutput("abort_bcd", 32'(bcd), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);

        applyStimulus(8'd42, 1'b1, 16'h0042);
        waitIdle();

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
